fetch_seq_ctrl: RTL and testbench

Sequences the program counter for the MIPS core. Holds the architectural PC and issues instruction-memory requests with a valid/ready handshake. Presents the fetched instruction and PC+4 to the next-PC logic and decode. Accepts the next-PC result (branch/jump redirect) or falls through to PC+4 when the consumer advances.

---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/fetch_seq_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_seq_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS fetch sequencer.
package mips_fetch_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [ADDR_W-1:0] DEF_EXC_PC   = 32'h0000_4180;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_VALID = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_seq_ctrl.sv
// Fetch sequencer: holds the architectural PC, issues instruction-memory
// requests with a valid/ready handshake and presents the fetched word with
// pc/pc+4 to the consumer. On consume the PC takes the redirect target or
// falls through to pc+4.
// Optional build macro FETCH_ALIGN_CHECK_EN: a misaligned redirect target
// vectors to EXC_PC and pulses exc_misalign; without it the target's low two
// bits are cleared and exc_misalign stays 0.
module fetch_seq_ctrl
  import mips_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [ADDR_W-1:0] EXC_PC   = DEF_EXC_PC
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [ADDR_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc4,
  output logic [ADDR_W-1:0] instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] fetch_cnt,
  output logic              exc_misalign
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_instr;
  logic              r_instr_valid;
  logic [ADDR_W-1:0] r_fetch_cnt;
  logic              r_exc_misalign;

  logic              w_consume;
  logic              w_accept;
  logic [ADDR_W-1:0] w_pc4;
  logic [ADDR_W-1:0] w_load_pc;
  logic              w_load_exc;

  // pc+4 wraps naturally in 32 bits; it is purely combinational from r_pc.
  assign w_pc4     = r_pc + 32'd4;
  assign w_consume = (r_state == ST_VALID) && !stall;
  assign w_accept  = (r_state == ST_FETCH) && imem_ready;

`ifdef FETCH_ALIGN_CHECK_EN
  // A redirect with nonzero low bits vectors to the exception handler.
  always_comb begin
    w_load_pc  = w_pc4;
    w_load_exc = 1'b0;
    if (redirect_valid) begin
      if (redirect_pc[1:0] != 2'b00) begin
        w_load_pc  = EXC_PC;
        w_load_exc = 1'b1;
      end else begin
        w_load_pc  = redirect_pc;
      end
    end
  end
`else
  // Without the alignment check the target is silently word-aligned.
  always_comb begin
    w_load_pc  = w_pc4;
    w_load_exc = 1'b0;
    if (redirect_valid) begin
      w_load_pc = {redirect_pc[ADDR_W-1:2], 2'b00};
    end
  end

  // The low target bits and the exception vector have no role in this build.
  logic w_unused;
  assign w_unused = &{1'b0, redirect_pc[1:0], EXC_PC};
`endif

  // Next-state logic and the request strobe decoded from the current state.
  always_comb begin
    w_state_next = r_state;
    imem_req     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) w_state_next = ST_VALID;
      end
      ST_VALID: begin
        if (!stall) w_state_next = ST_FETCH;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register; reset drops imem_req immediately since it decodes ST_FETCH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_next;
  end

  // PC, instruction latch, consume counter and misalignment pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc           <= RESET_PC;
      r_instr        <= '0;
      r_instr_valid  <= 1'b0;
      r_fetch_cnt    <= '0;
      r_exc_misalign <= 1'b0;
    end else begin
      r_exc_misalign <= 1'b0;
      if (w_accept) begin
        r_instr       <= imem_rdata;
        r_instr_valid <= 1'b1;
      end
      if (w_consume) begin
        r_pc           <= w_load_pc;
        r_instr_valid  <= 1'b0;
        r_fetch_cnt    <= r_fetch_cnt + 32'd1;
        r_exc_misalign <= w_load_exc;
      end
    end
  end

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign pc4          = w_pc4;
  assign instr        = r_instr;
  assign instr_valid  = r_instr_valid;
  assign fetch_cnt    = r_fetch_cnt;
  assign exc_misalign = r_exc_misalign;

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Testbench for fetch_seq_ctrl: a directed stimulus process pushes expected
// fetch addresses and consumed PCs into queues; a monitor pops and compares
// whenever the DUT presents an accepted fetch or a consumed instruction.
// Expectations follow FETCH_ALIGN_CHECK_EN when it is defined.
module tb_fetch_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] fetch_cnt;
  logic        exc_misalign;

  int tests  = 0;
  int errors = 0;

  logic [31:0] exp_fetch[$];
  logic [31:0] exp_cons[$];

  fetch_seq_ctrl dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .pc(pc), .pc4(pc4), .instr(instr), .instr_valid(instr_valid),
    .fetch_cnt(fetch_cnt), .exc_misalign(exc_misalign)
  );

  always #5 clk = ~clk;

  // Memory model: data is a fixed scramble of the address, garbage when not ready.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h5A5A_0F0F;
  endfunction
  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %h", name, act);
    end
  endtask

  // Inputs change 1 time unit after the rising edge and govern the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

`ifdef FETCH_ALIGN_CHECK_EN
  localparam logic [31:0] MIS_PC  = 32'h0000_4180;
  localparam logic [31:0] MIS_EXC = 32'd1;
`else
  localparam logic [31:0] MIS_PC  = 32'h0000_3040;
  localparam logic [31:0] MIS_EXC = 32'd0;
`endif

  // Monitor: accepted fetches and consumed instructions are scored in order.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (imem_req && imem_ready) begin
          if (exp_fetch.size() == 0) begin
            tests++; errors++;
            $display("FAIL fetch_unexpected: got addr %h expected no fetch", imem_addr);
          end else begin
            e = exp_fetch.pop_front();
            chk("fetch_addr", imem_addr, e);
          end
        end
        if (instr_valid && !stall) begin
          if (exp_cons.size() == 0) begin
            tests++; errors++;
            $display("FAIL consume_unexpected: got pc %h expected no consume", pc);
          end else begin
            e = exp_cons.pop_front();
            chk("consume_pc", pc, e);
            chk("consume_instr", instr, mem_word(e));
            chk("consume_pc4", pc4, e + 32'd4);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;

    exp_fetch = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3040,
                  32'hFFFF_FFFC, 32'h0000_0000, MIS_PC, 32'h3000};
    exp_cons  = '{32'h3000, 32'h3004, 32'h3008, 32'h300C, 32'h3040,
                  32'hFFFF_FFFC, 32'h0000_0000, MIS_PC, 32'h3000};

    step();
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h3000);
    chk("rst_pc4", pc4, 32'h3004);
    chk("rst_instr", instr, 32'h0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_fetch_cnt", fetch_cnt, 32'd0);
    chk("rst_exc", {31'd0, exc_misalign}, 32'd0);
    reset = 1'b1;
    chk("idle_imem_req", {31'd0, imem_req}, 32'd0);

    step();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'h3000);
    step();
    chk("first_valid", {31'd0, instr_valid}, 32'd1);
    chk("first_pc", pc, 32'h3000);
    chk("first_pc4", pc4, 32'h3004);
    step(); step(); step();
    step();
    imem_ready = 1'b0;                       // third instruction being consumed
    step();
    chk("cnt_after_3", fetch_cnt, 32'd3);

    // Memory wait: three cycles in FETCH with ready low.
    for (int i = 0; i < 3; i++) begin
      if (i > 0) step();
      chk("wait_req", {31'd0, imem_req}, 32'd1);
      chk("wait_addr", imem_addr, 32'h300C);
      chk("wait_valid", {31'd0, instr_valid}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    chk("wait_done_valid", {31'd0, instr_valid}, 32'd1);

    // Stall with a pending redirect for four cycles.
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h3040;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_pc", pc, 32'h300C);
      chk("stall_instr", instr, mem_word(32'h300C));
      chk("stall_valid", {31'd0, instr_valid}, 32'd1);
    end
    chk("stall_cnt", fetch_cnt, 32'd3);
    stall = 1'b0;
    step();
    chk("redir_addr", imem_addr, 32'h3040);
    redirect_pc = 32'hBAD0_0000;             // must be ignored in FETCH
    step();
    chk("redir_pc", pc, 32'h3040);
    redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    step();
    chk("wrap_pc4", pc4, 32'h0000_0000);
    step();
    chk("wrap_addr", imem_addr, 32'h0000_0000);
    step();
    redirect_valid = 1'b1; redirect_pc = 32'h3042;
    step();
    redirect_valid = 1'b0;
    chk("mis_pc", pc, MIS_PC);
    chk("mis_exc", {31'd0, exc_misalign}, MIS_EXC);
    step();
    chk("mis_exc_drop", {31'd0, exc_misalign}, 32'd0);
    imem_ready = 1'b0;
    step();
    chk("pre_rst_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_pc", pc, 32'h3000);
    chk("async_rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("async_rst_cnt", fetch_cnt, 32'd0);
    step();
    reset = 1'b1; imem_ready = 1'b1;
    step();
    step();
    imem_ready = 1'b0;
    step();
    chk("end_cnt", fetch_cnt, 32'd1);
    chk("fetch_q_left", exp_fetch.size(), 32'd0);
    chk("cons_q_left", exp_cons.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
